// File: rtl/clock_monitor_if.sv
// Control and result bundle of the clock monitor.
// Stats signals exist only with CLOCK_MONITOR_STATS_EN.
interface clock_monitor_if;
    logic        enable_i;
    logic        mon_in;
    logic [31:0] exp_period_i;
    logic [15:0] tol_i;
    logic [31:0] period_o;
    logic        period_valid_o;
    logic        in_range_o;
    logic        timeout_o;
`ifdef CLOCK_MONITOR_STATS_EN
    logic [31:0] min_period_o;
    logic [31:0] max_period_o;
    logic [15:0] err_cnt_o;
`endif

    modport master (
        output enable_i,
        output mon_in,
        output exp_period_i,
        output tol_i,
`ifdef CLOCK_MONITOR_STATS_EN
        input  min_period_o,
        input  max_period_o,
        input  err_cnt_o,
`endif
        input  period_o,
        input  period_valid_o,
        input  in_range_o,
        input  timeout_o
    );

    modport slave (
        input  enable_i,
        input  mon_in,
        input  exp_period_i,
        input  tol_i,
`ifdef CLOCK_MONITOR_STATS_EN
        output min_period_o,
        output max_period_o,
        output err_cnt_o,
`endif
        output period_o,
        output period_valid_o,
        output in_range_o,
        output timeout_o
    );
endinterface

// File: rtl/clock_monitor.sv
// Measures rising-to-rising period of a slow async signal.
// Optional min/max/error stats: define CLOCK_MONITOR_STATS_EN.
module clock_monitor #(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd200_000_000
) (
    input logic            clk_in,
    input logic            resetn_i,
    clock_monitor_if.slave mon
);
    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MEASURE,
        LOST
    } state_e;

    state_e state_q, state_d;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic        dly_q, dly_d;
    logic        rise;
    logic [31:0] cnt_q, cnt_d, cnt_inc;
    logic [31:0] period_q, period_d;
    logic        valid_q, valid_d;
    logic        in_range_q, in_range_d;
    logic        timeout_q, timeout_d;
    logic [32:0] diff, abs_diff;
    logic        in_tol;
    logic        at_limit;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], mon.mon_in};
        dly_d  = sync_q[SYNC_STAGES-1];
    end

    assign rise     = sync_q[SYNC_STAGES-1] & ~dly_q;
    assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + 32'd1;
    assign at_limit = (cnt_q == TIMEOUT_CYCLES);

    // Two's-complement magnitude of the 33-bit difference
    always_comb begin
        diff     = {1'b0, cnt_q} - {1'b0, mon.exp_period_i};
        abs_diff = diff[32] ? (~diff + 33'd1) : diff;
        in_tol   = (abs_diff <= {17'd0, mon.tol_i});
    end

    always_ff @(posedge clk_in or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q    <= IDLE;
            sync_q     <= '0;
            dly_q      <= 1'b0;
            cnt_q      <= '0;
            period_q   <= '0;
            valid_q    <= 1'b0;
            in_range_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync_q     <= sync_d;
            dly_q      <= dly_d;
            cnt_q      <= cnt_d;
            period_q   <= period_d;
            valid_q    <= valid_d;
            in_range_q <= in_range_d;
            timeout_q  <= timeout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!mon.enable_i) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:    state_d = ARM;
                ARM:     if (rise) state_d = MEASURE;
                MEASURE: if (!rise && at_limit) state_d = LOST;
                LOST:    if (rise) state_d = MEASURE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        cnt_d      = cnt_q;
        period_d   = period_q;
        valid_d    = 1'b0;
        in_range_d = in_range_q;
        timeout_d  = timeout_q;
        if (state_d == IDLE) begin
            cnt_d      = '0;
            in_range_d = 1'b0;
            timeout_d  = 1'b0;
        end else begin
            unique case (state_q)
                ARM: begin
                    if (rise) cnt_d = 32'd1;
                end
                MEASURE: begin
                    if (rise) begin
                        period_d   = cnt_q;
                        valid_d    = 1'b1;
                        in_range_d = in_tol;
                        cnt_d      = 32'd1;
                    end else if (at_limit) begin
                        timeout_d  = 1'b1;
                        in_range_d = 1'b0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                LOST: begin
                    if (rise) begin
                        cnt_d     = 32'd1;
                        timeout_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mon.period_o       = period_q;
    assign mon.period_valid_o = valid_q;
    assign mon.in_range_o     = in_range_q;
    assign mon.timeout_o      = timeout_q;

`ifdef CLOCK_MONITOR_STATS_EN
    logic [31:0] min_q, min_d;
    logic [31:0] max_q, max_d;
    logic [15:0] err_q, err_d;
    logic        err_ev;

    assign err_ev = (valid_d & ~in_tol)
                  | (state_q == MEASURE && state_d == LOST);

    always_comb begin
        min_d = min_q;
        max_d = max_q;
        err_d = err_q;
        if (state_d == IDLE) begin
            min_d = '1;
            max_d = '0;
            err_d = '0;
        end else begin
            if (valid_d && cnt_q < min_q) min_d = cnt_q;
            if (valid_d && cnt_q > max_q) max_d = cnt_q;
            if (err_ev && err_q != '1) err_d = err_q + 16'd1;
        end
    end

    always_ff @(posedge clk_in or negedge resetn_i) begin
        if (!resetn_i) begin
            min_q <= '1;
            max_q <= '0;
            err_q <= '0;
        end else begin
            min_q <= min_d;
            max_q <= max_d;
            err_q <= err_d;
        end
    end

    assign mon.min_period_o = min_q;
    assign mon.max_period_o = max_q;
    assign mon.err_cnt_o    = err_q;
`endif
endmodule

// File: doc/clock_monitor.md
CLOCK_MONITOR -- requirements
Module: clock_monitor

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of mon_in synchronizer flops (legal range 2..4).
REQ-002 Parameter TIMEOUT_CYCLES, default 200000000, missing-edge limit in clk_in cycles (32-bit).
REQ-003 clk_in  input  1  single clock for all logic.
REQ-004 resetn_i  input  1  reset, asynchronous assert, active-low.
REQ-005 enable_i  input  1  monitor enable, synchronous to clk_in.
REQ-006 mon_in  input  1  monitored slow signal, e.g. a 1 kHz/1 Hz debug clock, asynchronous to clk_in.
REQ-007 exp_period_i  input  32  expected period in clk_in cycles; static while enable_i=1.
REQ-008 tol_i  input  16  allowed deviation in cycles; static while enable_i=1.
REQ-009 period_o  output  32  last measured rising-to-rising period in clk_in cycles.
REQ-010 period_valid_o  output  1  one-cycle pulse on each period_o update.
REQ-011 in_range_o  output  1  last period within exp_period_i +/- tol_i.
REQ-012 timeout_o  output  1  no rising edge within TIMEOUT_CYCLES.
REQ-013 With CLOCK_MONITOR_STATS_EN only: min_period_o out 32, max_period_o out 32, err_cnt_o out 16.

Function
REQ-014 mon_in shall pass through SYNC_STAGES flops; a rise is sync output=1 while its one-cycle-delayed copy=0; falling edges are ignored.
REQ-015 FSM states: IDLE, ARM, MEASURE, LOST; IDLE->ARM when enable_i=1; any state->IDLE in the cycle after enable_i=0.
REQ-016 ARM: on rise, cnt<=1, go MEASURE; no period_valid_o pulse for the first edge.
REQ-017 MEASURE: without rise, cnt<=cnt+1 saturating at 32'hFFFFFFFF; on rise, period_o<=cnt, period_valid_o<=1 for one cycle, cnt<=1.
REQ-018 mon_in first sampled high at edge N shall give period_valid_o high after edge N+SYNC_STAGES.
REQ-019 in_range_o shall update with period_valid_o as |cnt - exp_period_i| <= tol_i using 33-bit signed difference; hold otherwise.
REQ-020 MEASURE with cnt==TIMEOUT_CYCLES and no rise: go LOST, timeout_o<=1, in_range_o<=0.
REQ-021 LOST: timeout_o held 1; on rise, cnt<=1, timeout_o<=0, go MEASURE, no period_valid_o for that edge.
REQ-022 Rise in same cycle as timeout condition: rise wins (period captured, no timeout).
REQ-023 Entering IDLE: cnt, period_valid_o, in_range_o, timeout_o cleared; period_o holds last value.

Reset
REQ-024 resetn_i low shall immediately clear sync flops, cnt, FSM (IDLE), period_o=0, period_valid_o=0, in_range_o=0, timeout_o=0, and stats outputs.
REQ-025 Reset mid-measurement shall discard the partial count; first period after release is measured only after ARM sees one rise.

Configuration
REQ-026 Macro CLOCK_MONITOR_STATS_EN defined: min_period_o (reset/IDLE value 32'hFFFFFFFF), max_period_o (reset/IDLE 0) update on each period_valid_o; err_cnt_o increments, saturating at 16'hFFFF, on each out-of-range period and each MEASURE->LOST transition; all cleared on entering IDLE.
REQ-027 Macro undefined: stats ports and logic absent; all other behaviour identical.

Verification
REQ-028 mon_in period 10 cycles, exp=10, tol=0 -> period_valid_o every 10 cycles, period_o=10, in_range_o=1; first edge produces no pulse.
REQ-029 period 12, exp=10, tol=1 -> period_o=12, in_range_o=0; with STATS_EN err_cnt_o increments per period, max_period_o=12.
REQ-030 TIMEOUT_CYCLES=50, mon_in stuck low after one rise -> timeout_o=1 after cnt reaches 50; next rise clears timeout_o, no valid pulse, following rise gives valid period.
REQ-031 mon_in high sampled at edge N, SYNC_STAGES=3 -> period_valid_o high after edge N+3.
REQ-032 resetn_i low mid-period then released, and separately enable_i dropped -> outputs at reset/IDLE values, period_o holds on enable drop only, measurement restarts from ARM.
